// File: rtl/calc_exec.sv
// RPN command sequencer: validates stack depth for one command, then drives the
// operand stack through the pop/compute/push sequence and reports status.
module calc_exec #(
  parameter int DEPTH = 512,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  input  logic [3:0]   cmd_op,
  input  logic [W-1:0] cmd_num,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [1:0]   err_code,
  output logic [W-1:0] result,
  output logic         stk_push,
  output logic         stk_pop,
  output logic [W-1:0] stk_in,
  input  logic [9:0]   stk_size,
  input  logic [W-1:0] stk_top,
  input  logic         stk_error,
  output logic         stack_fault
);

  // Handshake: a command is taken on any edge where cmd_valid=1 and busy=0;
  // busy stays high until the single-cycle done pulse, and requests seen while
  // busy are dropped rather than queued.

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_PUSH  = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_MUL   = 4'd4;
  localparam logic [3:0] OP_NEG   = 4'd5;
  localparam logic [3:0] OP_DUP   = 4'd6;
  localparam logic [3:0] OP_SWAP  = 4'd7;
  localparam logic [3:0] OP_DROP  = 4'd8;
  localparam logic [3:0] OP_CLEAR = 4'd9;

  localparam logic [1:0] EC_OK      = 2'd0;
  localparam logic [1:0] EC_UNDER   = 2'd1;
  localparam logic [1:0] EC_OVER    = 2'd2;
  localparam logic [1:0] EC_ILLEGAL = 2'd3;

  localparam logic [9:0] DEPTH_L = 10'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_PUSH, S_POP_B, S_POP_A, S_PUSH2, S_CLR, S_DONE
  } state_t;

  state_t       state;
  logic [3:0]   op;
  logic [W-1:0] b;
  logic [W-1:0] pdata;
  logic [W-1:0] pdata2;

  logic [1:0]   acc_code;
  state_t       acc_next;
  logic         full;
  logic [W-1:0] alu;

  assign full = (stk_size >= DEPTH_L);

  // Depth pre-check on the stack size seen at the acceptance edge.
  always_comb begin
    acc_code = EC_OK;
    acc_next = S_DONE;
    case (cmd_op)
      OP_NOP: acc_next = S_DONE;
      OP_PUSH: begin
        if (full) acc_code = EC_OVER;
        else      acc_next = S_PUSH;
      end
      OP_ADD, OP_SUB, OP_MUL, OP_SWAP: begin
        if (stk_size < 10'd2) acc_code = EC_UNDER;
        else                  acc_next = S_POP_B;
      end
      OP_NEG, OP_DROP: begin
        if (stk_size == 10'd0) acc_code = EC_UNDER;
        else                   acc_next = S_POP_B;
      end
      OP_DUP: begin
        if (stk_size == 10'd0) acc_code = EC_UNDER;
        else if (full)         acc_code = EC_OVER;
        else                   acc_next = S_PUSH;
      end
      OP_CLEAR: acc_next = S_CLR;
      default:  acc_code = EC_ILLEGAL;
    endcase
  end

  // In POP_A stk_top already shows operand a; b was latched a cycle earlier.
  always_comb begin
    alu = '0;
    case (op)
      OP_ADD:  alu = stk_top + b;
      OP_SUB:  alu = stk_top - b;
      OP_MUL:  alu = stk_top * b;
      OP_SWAP: alu = b;
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      op          <= OP_NOP;
      b           <= '0;
      pdata       <= '0;
      pdata2      <= '0;
      err         <= 1'b0;
      err_code    <= EC_OK;
      result      <= '0;
      stack_fault <= 1'b0;
    end else begin
      if (state != S_IDLE && stk_error) stack_fault <= 1'b1;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op       <= cmd_op;
            err      <= (acc_code != EC_OK);
            err_code <= acc_code;
            pdata    <= (cmd_op == OP_DUP) ? stk_top : cmd_num;
            state    <= acc_next;
          end
        end
        S_POP_B: begin
          b <= stk_top;
          case (op)
            OP_NEG: begin
              pdata <= '0 - stk_top;
              state <= S_PUSH;
            end
            OP_DROP: state <= S_DONE;
            default: state <= S_POP_A;
          endcase
        end
        S_POP_A: begin
          pdata  <= alu;
          pdata2 <= stk_top;
          state  <= S_PUSH;
        end
        S_PUSH: begin
          result <= pdata;
          state  <= (op == OP_SWAP) ? S_PUSH2 : S_DONE;
        end
        S_PUSH2: begin
          result <= pdata2;
          state  <= S_DONE;
        end
        S_CLR: begin
          if (stk_size == 10'd0) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign stk_push = (state == S_PUSH) || (state == S_PUSH2);
  assign stk_pop  = (state == S_POP_B) || (state == S_POP_A) ||
                    ((state == S_CLR) && (stk_size != 10'd0));
  assign stk_in   = (state == S_PUSH)  ? pdata  :
                    (state == S_PUSH2) ? pdata2 : '0;

endmodule

// File: tb/tb_calc_exec.sv
// Directed bench for calc_exec with a behavioural operand stack attached.
module tb_calc_exec;
  localparam int W = 32;
  localparam int DEPTH = 512;

  localparam logic [3:0] OP_NOP = 4'd0, OP_PUSH = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3;
  localparam logic [3:0] OP_MUL = 4'd4, OP_NEG = 4'd5, OP_DUP = 4'd6, OP_SWAP = 4'd7;
  localparam logic [3:0] OP_DROP = 4'd8, OP_CLEAR = 4'd9;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic [3:0]   cmd_op;
  logic [W-1:0] cmd_num;
  logic         busy, done, err;
  logic [1:0]   err_code;
  logic [W-1:0] result;
  logic         stk_push, stk_pop;
  logic [W-1:0] stk_in;
  logic [9:0]   stk_size;
  logic [W-1:0] stk_top;
  logic         stk_error;
  logic         stack_fault;

  calc_exec #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_num(cmd_num), .busy(busy), .done(done), .err(err), .err_code(err_code),
    .result(result), .stk_push(stk_push), .stk_pop(stk_pop), .stk_in(stk_in),
    .stk_size(stk_size), .stk_top(stk_top), .stk_error(stk_error),
    .stack_fault(stack_fault)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  // ---- behavioural operand stack ----
  logic [W-1:0] mem [0:DEPTH-1];
  logic [9:0]   size_q;
  logic         err_inj;

  always @(posedge clk) begin
    if (reset) size_q <= '0;
    else if (stk_push && size_q < 10'(DEPTH)) begin
      mem[size_q[8:0]] <= stk_in;
      size_q <= size_q + 10'd1;
    end else if (stk_pop && size_q != 10'd0) begin
      size_q <= size_q - 10'd1;
    end
  end

  logic [9:0] top_idx;
  assign top_idx   = size_q - 10'd1;
  assign stk_size  = size_q;
  assign stk_top   = (size_q != 10'd0) ? mem[top_idx[8:0]] : '0;
  assign stk_error = err_inj;

  function automatic logic [W-1:0] second_entry();
    logic [9:0] idx;
    idx = size_q - 10'd2;
    return mem[idx[8:0]];
  endfunction

  // ---- scoreboard ----
  int total = 0;
  int bad = 0;
  logic [W:0] exp_q[$];
  bit track;
  int lat, n_pop, n_push;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] ev_push(input logic [W-1:0] v);
    return {1'b1, v};
  endfunction

  function automatic logic [W:0] ev_pop();
    return {1'b0, {W{1'b0}}};
  endfunction

  // ---- driver ----
  task automatic run_cmd(input logic [3:0] op, input logic [W-1:0] num,
                         input bit poke, input bit inject);
    bit got_done;
    logic [W:0] ev;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_num   = num;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0; n_pop = 0; n_push = 0;
    got_done = 1'b0;
    for (int i = 0; i < 2000 && !got_done; i++) begin
      @(negedge clk);
      lat++;
      err_inj = inject && (lat == 1);
      check("push_pop_exclusive", 64'(stk_push & stk_pop), 64'(0));
      if (stk_pop)  n_pop++;
      if (stk_push) n_push++;
      if (track && (stk_pop || stk_push)) begin
        ev = {stk_push, stk_in};
        if (exp_q.size() == 0) check("ev_extra", 64'(ev), 64'(0));
        else                   check("ev_order", 64'(ev), 64'(exp_q.pop_front()));
      end
      if (done) begin
        got_done = 1'b1;
        check("busy_at_done", 64'(busy), 64'(1));
      end
      if (poke) begin
        cmd_valid = !done;
        cmd_op    = OP_PUSH;
        cmd_num   = 32'd99;
      end
    end
    err_inj   = 1'b0;
    cmd_valid = 1'b0;
    if (!got_done) check("done_timeout", 64'(0), 64'(1));
  endtask

  task automatic push_val(input logic [W-1:0] v);
    run_cmd(OP_PUSH, v, 1'b0, 1'b0);
  endtask

  // ---- directed sequence ----
  initial begin
    logic [9:0] sz_before;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_num = '0;
    err_inj = 1'b0; track = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'({err, err_code}), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_strobes", 64'({stk_push, stk_pop}), 64'(0));
    check("rst_stk_in", 64'(stk_in), 64'(0));
    check("rst_fault", 64'(stack_fault), 64'(0));
    reset = 1'b0;

    // 5 - 7 wraps to -2
    push_val(32'd5);
    check("push_lat", 64'(lat), 64'(2));
    check("push_cnt", 64'(n_push), 64'(1));
    push_val(32'd7);
    run_cmd(OP_SUB, '0, 1'b0, 1'b0);
    check("sub_lat", 64'(lat), 64'(4));
    check("sub_err", 64'({err, err_code}), 64'(0));
    check("sub_result", 64'(result), 64'(32'hFFFF_FFFE));
    check("sub_size", 64'(stk_size), 64'(1));
    check("sub_top", 64'(stk_top), 64'(32'hFFFF_FFFE));

    run_cmd(OP_DROP, '0, 1'b0, 1'b0);
    check("drop_lat", 64'(lat), 64'(2));
    check("drop_size", 64'(stk_size), 64'(0));
    check("drop_result", 64'(result), 64'(32'hFFFF_FFFE));

    // underflow on empty stack
    run_cmd(OP_ADD, '0, 1'b0, 1'b0);
    check("uf_lat", 64'(lat), 64'(1));
    check("uf_err", 64'({err, err_code}), 64'(3'b101));
    check("uf_strobes", 64'(n_pop + n_push), 64'(0));
    check("uf_size", 64'(stk_size), 64'(0));

    push_val(32'd1);
    run_cmd(OP_NEG, '0, 1'b0, 1'b0);
    check("neg_lat", 64'(lat), 64'(3));
    check("neg_top", 64'(stk_top), 64'(32'hFFFF_FFFF));
    check("neg_err", 64'(err), 64'(0));
    run_cmd(OP_DROP, '0, 1'b0, 1'b0);

    // SWAP ordering: pop, pop, push former top (9), push 3
    push_val(32'd3);
    push_val(32'd9);
    exp_q = {ev_pop(), ev_pop(), ev_push(32'd9), ev_push(32'd3)};
    track = 1'b1;
    run_cmd(OP_SWAP, '0, 1'b0, 1'b0);
    track = 1'b0;
    check("swap_lat", 64'(lat), 64'(5));
    check("swap_ev_left", 64'(exp_q.size()), 64'(0));
    check("swap_top", 64'(stk_top), 64'(3));
    check("swap_second", 64'(second_entry()), 64'(9));
    check("swap_result", 64'(result), 64'(3));

    push_val(32'h1_0000);
    push_val(32'h1_0000);
    run_cmd(OP_MUL, '0, 1'b0, 1'b0);
    check("mul_lat", 64'(lat), 64'(4));
    check("mul_top", 64'(stk_top), 64'(0));
    check("mul_result", 64'(result), 64'(0));
    check("mul_size", 64'(stk_size), 64'(3));

    push_val(32'd4);
    run_cmd(OP_CLEAR, '0, 1'b0, 1'b0);
    check("clr4_pops", 64'(n_pop), 64'(4));
    check("clr4_lat", 64'(lat), 64'(6));
    check("clr4_size", 64'(stk_size), 64'(0));
    check("clr4_err", 64'(err), 64'(0));
    run_cmd(OP_CLEAR, '0, 1'b0, 1'b0);
    check("clr0_lat", 64'(lat), 64'(2));
    check("clr0_pops", 64'(n_pop), 64'(0));

    run_cmd(4'd12, '0, 1'b0, 1'b0);
    check("ill_lat", 64'(lat), 64'(1));
    check("ill_err", 64'({err, err_code}), 64'(3'b111));
    run_cmd(OP_NOP, '0, 1'b0, 1'b0);
    check("nop_lat", 64'(lat), 64'(1));
    check("nop_err_clear", 64'({err, err_code}), 64'(0));

    // requests while busy must be dropped
    run_cmd(OP_PUSH, 32'd42, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("busy_ign_busy", 64'(busy), 64'(0));
    check("busy_ign_size", 64'(stk_size), 64'(1));
    check("busy_ign_top", 64'(stk_top), 64'(42));

    // fill to capacity
    for (int i = 0; i < DEPTH && stk_size < 10'(DEPTH); i++) push_val(32'(i));
    check("fill_size", 64'(stk_size), 64'(DEPTH));
    run_cmd(OP_PUSH, 32'd1, 1'b0, 1'b0);
    check("of_push_err", 64'({err, err_code}), 64'(3'b110));
    check("of_push_lat", 64'(lat), 64'(1));
    check("of_push_cnt", 64'(n_push), 64'(0));
    check("of_push_size", 64'(stk_size), 64'(DEPTH));
    run_cmd(OP_DUP, '0, 1'b0, 1'b0);
    check("of_dup_err", 64'({err, err_code}), 64'(3'b110));
    run_cmd(OP_CLEAR, '0, 1'b0, 1'b0);
    check("clr_full_pops", 64'(n_pop), 64'(DEPTH));
    check("clr_full_lat", 64'(lat), 64'(DEPTH + 2));
    check("clr_full_size", 64'(stk_size), 64'(0));

    run_cmd(OP_DUP, '0, 1'b0, 1'b0);
    check("uf_dup_err", 64'({err, err_code}), 64'(3'b101));
    push_val(32'd6);
    run_cmd(OP_DUP, '0, 1'b0, 1'b0);
    check("dup_lat", 64'(lat), 64'(2));
    check("dup_size", 64'(stk_size), 64'(2));
    check("dup_result", 64'(result), 64'(6));

    // stack error while busy: sticky flag, sequence unaffected
    check("fault_before", 64'(stack_fault), 64'(0));
    exp_q = {ev_pop(), ev_pop(), ev_push(32'd12)};
    track = 1'b1;
    run_cmd(OP_ADD, '0, 1'b0, 1'b1);
    track = 1'b0;
    check("fault_add_lat", 64'(lat), 64'(4));
    check("fault_add_result", 64'(result), 64'(12));
    check("fault_set", 64'(stack_fault), 64'(1));
    run_cmd(OP_NOP, '0, 1'b0, 1'b0);
    check("fault_sticky", 64'(stack_fault), 64'(1));

    // reset during POP_A of an ADD
    push_val(32'd1);
    push_val(32'd2);
    sz_before = stk_size;
    check("pre_rst_size", 64'(sz_before), 64'(3));
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_num = '0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_popb", 64'(stk_pop), 64'(1));
    @(negedge clk);
    check("rst_popa", 64'(stk_pop), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_pop", 64'(stk_pop), 64'(0));
    check("mid_rst_push", 64'(stk_push), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    check("mid_rst_err", 64'(err), 64'(0));
    check("mid_rst_fault", 64'(stack_fault), 64'(0));
    reset = 1'b0;
    push_val(32'd1);
    check("post_rst_lat", 64'(lat), 64'(2));
    check("post_rst_result", 64'(result), 64'(1));
    check("post_rst_err", 64'(err), 64'(0));
    check("post_rst_size", 64'(stk_size), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/calc_exec.md
Name: calc_exec

Overview:
- Command sequencer that drives the calculator's operand stack as its initiator.
- Accepts one RPN command at a time, checks stack depth, then issues the pop/push sequence for that command.
- Computes the result, pushes it back, and reports completion and error status.
- Sits between the command decoder (keypad/UART parser) and the operand stack; the stack's size/top/error outputs feed back into this block.

Parameters:
- DEPTH, 512, stack capacity; a push is legal only while stk_size < DEPTH.
- W, 32, data width of operands and results.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command strobe; sampled only when busy=0
- cmd_op  in  4  opcode
- cmd_num  in  W  literal for PUSH
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  one-cycle completion pulse
- err  out  1  command failed; valid with done, held until next acceptance
- err_code  out  2  0=OK, 1=UNDERFLOW, 2=OVERFLOW, 3=ILLEGAL; held like err
- result  out  W  last value pushed by this block; held
- stk_push  out  1  push strobe to stack
- stk_pop  out  1  pop strobe to stack
- stk_in  out  W  data to stack, valid with stk_push
- stk_size  in  10  current stack depth
- stk_top  in  W  current top of stack; updated at the same edge as push/pop
- stk_error  in  1  stack error flag
- stack_fault  out  1  sticky: stk_error seen while busy

Behaviour:
- Reset: state IDLE; all outputs 0.
- Reset mid-operation aborts the sequence; stk_push and stk_pop drop in the cycle after the reset edge.
- stk_push, stk_pop and stk_in decode from registered state only; there is no combinational path from cmd_* to stack strobes.
- Never assert stk_push and stk_pop in the same cycle.
- Acceptance:
  - IDLE with cmd_valid=1 at edge T accepts the command.
  - The same edge latches op and num, and clears err and err_code.
  - cmd_valid while busy is ignored, not queued.
- Pre-check at acceptance, on the stk_size value at T:
  - If the check fails, go to DONE with no stack strobes issued.
  - Required depth: ADD/SUB/MUL/SWAP need size>=2. NEG/DROP need size>=1. DUP needs 1<=size<DEPTH. PUSH needs size<DEPTH.
  - Too few entries gives UNDERFLOW. Full stack on PUSH/DUP gives OVERFLOW.
- Opcodes and cycle sequences (T = accept edge, one state per cycle):
  - 0 NOP: DONE at T+1.
  - 1 PUSH: PUSH (stk_in=num) at T+1, DONE at T+2.
  - 2 ADD / 3 SUB / 4 MUL:
    - POP_B at T+1: pop, latch b=stk_top.
    - POP_A at T+2: pop, latch a=stk_top.
    - PUSH at T+3: push f(a,b).
    - DONE at T+4.
    - SUB=a-b (b is the former top). MUL keeps the low W bits. All arithmetic wraps mod 2^W with no overflow flag.
  - 5 NEG: POP_B, then PUSH 0-b, then DONE (T+3).
  - 6 DUP: PUSH stk_top (sampled at acceptance), then DONE.
  - 7 SWAP: POP_B, POP_A, PUSH b, PUSH2 a, DONE at T+5. Result = a.
  - 8 DROP: POP_B, then DONE. result is unchanged.
  - 9 CLEAR:
    - In state CLR, stk_pop = (stk_size != 0) each cycle.
    - Exit to DONE in the cycle after stk_size reads 0.
    - Empty stack: CLR lasts 1 cycle, no pop.
    - CLEAR never errors.
  - 10..15: ILLEGAL, straight to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy=1 in every state except IDLE.
- result updates on each push issued by this block.
- stk_error=1 in any cycle while busy sets stack_fault. stack_fault is sticky until reset and does not alter the sequence.

Test Plan:
- Reset, then PUSH 5, PUSH 7, SUB → after SUB: stack size 1, top 0xFFFFFFFE, result 0xFFFFFFFE, err=0. done for SUB is exactly 4 cycles after acceptance.
- Empty stack, ADD → done at T+1, err=1, err_code=1, no stk_pop/stk_push pulses, size stays 0.
- Fill to 512 with PUSH, then PUSH 1 → err_code=2, size stays 512. DUP on the same full stack also gives err_code=2.
- PUSH 3, PUSH 9, SWAP → top=3 and second=9, pops/pushes in the order pop, pop, push 9, push 3, done at T+5. MUL 0x10000×0x10000 gives 0.
- PUSH ×4, CLEAR → exactly 4 stk_pop pulses, then done, size=0. Opcode 12 gives err_code=3. cmd_valid pulsed while busy is ignored.
- Assert reset in POP_A of an ADD → next cycle busy=0, stk_pop=0, done=0, err=0. A fresh PUSH 1 completes normally.
